wb_commit_buf: RTL

- In-order writeback commit buffer that sits directly upstream of the register file and feeds both of its write ports.
- Accepts up to two completed results per cycle from the execute/LSU pipes, in program order (slot 0 older, slot 1 younger).
- Holds them in a circular buffer and drains up to two per cycle onto the RF's we1/waddr1/wdata1 and we2/waddr2/wdata2 ports.
- Provides four pending-result lookup ports so the operand-read stage can forward values not yet in the RF.

---
 rtl/wb_commit_buf.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_commit_buf.sv
// In-order writeback commit buffer: accepts up to two results per cycle, drains up to
// two per cycle into the register file, and forwards pending values to operand read.
module wb_commit_buf #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in0_valid,
  input  logic [ADDR_W-1:0]         in0_addr,
  input  logic [DATA_W-1:0]         in0_data,
  input  logic                      in1_valid,
  input  logic [ADDR_W-1:0]         in1_addr,
  input  logic [DATA_W-1:0]         in1_data,
  output logic                      in_ready,
  input  logic                      drain_en,
  output logic                      we1,
  output logic [ADDR_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wdata1,
  output logic                      we2,
  output logic [ADDR_W-1:0]         waddr2,
  output logic [DATA_W-1:0]         wdata2,
  input  logic [ADDR_W-1:0]         qaddr0,
  input  logic [ADDR_W-1:0]         qaddr1,
  input  logic [ADDR_W-1:0]         qaddr2,
  input  logic [ADDR_W-1:0]         qaddr3,
  output logic                      qhit0,
  output logic                      qhit1,
  output logic                      qhit2,
  output logic                      qhit3,
  output logic [DATA_W-1:0]         qdata0,
  output logic [DATA_W-1:0]         qdata1,
  output logic [DATA_W-1:0]         qdata2,
  output logic [DATA_W-1:0]         qdata3,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nx;
  logic [CNT_W-1:0]  count_q, count_d, n_in, n_out;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              live0, live1;

  logic [ADDR_W-1:0] qa  [4];
  logic              qh  [4];
  logic [DATA_W-1:0] qd  [4];
  logic [PTR_W-1:0]  idx;

  always_comb begin
    live0    = in0_valid && (in0_addr != '0);
    live1    = in1_valid && (in1_addr != '0);
    in_ready = (count_q <= CNT_W'(DEPTH - 2));
    we1      = drain_en && (count_q != '0);
    we2      = drain_en && (count_q >= CNT_W'(2));
    head_nx  = head_q + 1'b1;
    waddr1   = we1 ? addr_q[head_q]  : '0;
    wdata1   = we1 ? data_q[head_q]  : '0;
    waddr2   = we2 ? addr_q[head_nx] : '0;
    wdata2   = we2 ? data_q[head_nx] : '0;
    n_in     = in_ready ? (CNT_W'(live0) + CNT_W'(live1)) : '0;
    n_out    = CNT_W'(we1) + CNT_W'(we2);
    count    = count_q;
    empty    = (count_q == '0);
  end

  // in1 lands right after in0 only when in0 actually consumed an entry
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (in_ready) begin
      if (live0) begin
        addr_d[tail_q] = in0_addr;
        data_d[tail_q] = in0_data;
      end
      if (live1) begin
        addr_d[tail_q + PTR_W'(live0)] = in1_addr;
        data_d[tail_q + PTR_W'(live0)] = in1_data;
      end
    end
    tail_d  = tail_q + PTR_W'(n_in);
    head_d  = head_q + PTR_W'(n_out);
    count_d = count_q + n_in - n_out;
  end

  // Walk oldest to youngest so the last match left standing is the youngest one
  always_comb begin
    qa[0] = qaddr0;
    qa[1] = qaddr1;
    qa[2] = qaddr2;
    qa[3] = qaddr3;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      qh[k] = 1'b0;
      qd[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (qa[k] != '0) && (addr_q[idx] == qa[k])) begin
          qh[k] = 1'b1;
          qd[k] = data_q[idx];
        end
      end
    end
    qhit0  = qh[0];
    qhit1  = qh[1];
    qhit2  = qh[2];
    qhit3  = qh[3];
    qdata0 = qd[0];
    qdata1 = qd[1];
    qdata2 = qd[2];
    qdata3 = qd[3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
